mem_access: RTL and testbench

MEM-stage load/store unit between the EX/MEM pipeline register and `MEM_WB`. It takes the memory-class instruction held in EX/MEM, runs one request/acknowledge transaction on the data-memory bus, aligns store lanes and extracts/extends load data, and raises a stall while the bus is busy. Every cycle it presents the `mem_*` / `memdata` bundle that `MEM_WB` captures, and it detects MIPS address-error conditions (AdEL/AdES).

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_align.sv | 53 +++++
 rtl/mem_access.sv | 106 ++++++++++
 tb/tb_mem_access.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: bus widths, access-size
// encodings and the bus-transaction FSM states.
package mem_access_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/data replication, load byte/halfword
// extraction with sign or zero extension, and address-alignment checking.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]        memop,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] wdata,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        wstrb,
    output logic [RegBus-1:0] wdata_lane,
    output logic [RegBus-1:0] ld_data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb      = '0;
        wdata_lane = ZeroWord;
        ld_data    = ZeroWord;
        misaligned = 1'b0;
        case (memop)
            MEM_B, MEM_BU: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                ld_data    = (memop == MEM_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'h0, byte_sel};
            end
            MEM_H, MEM_HU: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                ld_data    = (memop == MEM_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
                misaligned = addr_lo[0];
            end
            MEM_W: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
                ld_data    = rdata;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: runs one req/ack data-memory transaction per
// aligned memory instruction, stalls the front of the pipe, and feeds MEM_WB.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_MemRead,
    input  logic                  ex_MemWrite,
    input  logic                  ex_RegWrite,
    input  logic                  ex_MemtoReg,
    input  logic [2:0]            ex_memop,
    input  logic [RegBus-1:0]     ex_ALUResult,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [RegAddrBus-1:0] ex_regdst,
    output logic                  mem_RegWrite,
    output logic                  mem_MemtoReg,
    output logic [RegBus-1:0]     memdata,
    output logic [RegBus-1:0]     mem_ALUResult,
    output logic [RegAddrBus-1:0] mem_regdst,
    output logic                  stall_req,
    output logic                  excp_adel,
    output logic                  excp_ades,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [RegBus-1:0]     dm_addr,
    output logic [3:0]            dm_wstrb,
    output logic [RegBus-1:0]     dm_wdata,
    input  logic                  dm_ack,
    input  logic [RegBus-1:0]     dm_rdata
);

    mem_state_e        state, state_n;
    logic [RegBus-1:0] ld_buf;
    logic [RegBus-1:0] ld_data;
    logic              misaligned;
    logic              mem_op;
    logic              addr_err;
    logic              start;

    mem_align u_align (
        .memop      (ex_memop),
        .addr_lo    (ex_ALUResult[1:0]),
        .wdata      (ex_wdata),
        .rdata      (dm_rdata),
        .wstrb      (dm_wstrb),
        .wdata_lane (dm_wdata),
        .ld_data    (ld_data),
        .misaligned (misaligned)
    );

    // Qualified by rst so a flushed pipe reads as idle while reset is held.
    always_comb begin
        mem_op   = rst & ex_valid & (ex_MemRead | ex_MemWrite);
        addr_err = mem_op & misaligned;
        start    = mem_op & ~misaligned;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            ld_buf <= '0;
        end else begin
            state <= state_n;
            if (state == S_WAIT && dm_ack)
                ld_buf <= ld_data;
        end
    end

    always_comb begin
        state_n   = state;
        dm_req    = 1'b0;
        stall_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stall_req = 1'b1;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                dm_req    = 1'b1;
                stall_req = 1'b1;
                if (dm_ack)
                    state_n = S_RESP;
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Stalled cycles present a bubble to MEM_WB, which has no enable.
    always_comb begin
        excp_adel     = addr_err & ex_MemRead;
        excp_ades     = addr_err & ex_MemWrite;
        mem_RegWrite  = rst & ex_valid & ex_RegWrite & ~stall_req & ~addr_err;
        mem_MemtoReg  = rst & ex_valid & ex_MemtoReg & ~stall_req;
        memdata       = (state == S_RESP && ex_MemRead) ? ld_buf : ZeroWord;
        mem_ALUResult = ex_ALUResult;
        mem_regdst    = ex_regdst;
        dm_we         = ex_MemWrite;
        dm_addr       = {ex_ALUResult[31:2], 2'b00};
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of single-transaction vectors plus
// hand-written sequences for delayed ack, reset mid-transaction and back-to-back.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg;
    logic [2:0]  ex_memop;
    logic [31:0] ex_ALUResult, ex_wdata;
    logic [4:0]  ex_regdst;
    logic        mem_RegWrite, mem_MemtoReg;
    logic [31:0] memdata, mem_ALUResult;
    logic [4:0]  mem_regdst;
    logic        stall_req, excp_adel, excp_ades;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_memop(ex_memop),
        .ex_ALUResult(ex_ALUResult), .ex_wdata(ex_wdata), .ex_regdst(ex_regdst),
        .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg), .memdata(memdata),
        .mem_ALUResult(mem_ALUResult), .mem_regdst(mem_regdst), .stall_req(stall_req),
        .excp_adel(excp_adel), .excp_ades(excp_ades), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    typedef struct {
        string       name;
        logic [2:0]  memop;
        logic        rd, wr, rw, m2r, valid;
        logic [31:0] addr, wdata, rdata;
        logic        e_stall, e_adel, e_ades, e_rw, e_m2r;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata, e_memdata;
        logic        e_rw_resp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic clear_inputs();
        ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
        ex_RegWrite = 1'b0; ex_MemtoReg = 1'b0; ex_memop = 3'b000;
        ex_ALUResult = '0; ex_wdata = '0; ex_regdst = 5'd0;
    endtask

    task automatic apply(input logic [2:0] op, input logic rd, input logic wr,
                         input logic rw, input logic m2r, input logic valid,
                         input logic [31:0] addr, input logic [31:0] wd);
        ex_memop = op; ex_MemRead = rd; ex_MemWrite = wr; ex_RegWrite = rw;
        ex_MemtoReg = m2r; ex_valid = valid; ex_ALUResult = addr; ex_wdata = wd;
        ex_regdst = 5'd9;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        apply(v.memop, v.rd, v.wr, v.rw, v.m2r, v.valid, v.addr, v.wdata);
        dm_ack = 1'b0;
        @(negedge clk);
        chk({v.name, ".stall"},   {31'd0, stall_req},    {31'd0, v.e_stall});
        chk({v.name, ".adel"},    {31'd0, excp_adel},    {31'd0, v.e_adel});
        chk({v.name, ".ades"},    {31'd0, excp_ades},    {31'd0, v.e_ades});
        chk({v.name, ".regwr"},   {31'd0, mem_RegWrite}, {31'd0, v.e_rw});
        chk({v.name, ".memtoreg"},{31'd0, mem_MemtoReg}, {31'd0, v.e_m2r});
        chk({v.name, ".req_idle"},{31'd0, dm_req},       32'd0);
        chk({v.name, ".wstrb"},   {28'd0, dm_wstrb},     {28'd0, v.e_wstrb});
        chk({v.name, ".wdata"},   dm_wdata,              v.e_wdata);
        chk({v.name, ".addr"},    dm_addr,               v.addr & 32'hFFFF_FFFC);
        chk({v.name, ".we"},      {31'd0, dm_we},        {31'd0, v.wr});
        chk({v.name, ".memdata0"},memdata,               32'd0);
        if (v.e_stall) begin
            @(posedge clk); #1;
            dm_ack = 1'b1; dm_rdata = v.rdata;
            @(negedge clk);
            chk({v.name, ".req_wait"},  {31'd0, dm_req},       32'd1);
            chk({v.name, ".stall_wait"},{31'd0, stall_req},    32'd1);
            chk({v.name, ".rw_wait"},   {31'd0, mem_RegWrite}, 32'd0);
            @(posedge clk); #1;
            dm_ack = 1'b0;
            @(negedge clk);
            chk({v.name, ".stall_resp"},{31'd0, stall_req},    32'd0);
            chk({v.name, ".req_resp"},  {31'd0, dm_req},       32'd0);
            chk({v.name, ".memdata"},   memdata,               v.e_memdata);
            chk({v.name, ".rw_resp"},   {31'd0, mem_RegWrite}, {31'd0, v.e_rw_resp});
            chk({v.name, ".alu_resp"},  mem_ALUResult,         v.addr);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    int unsigned stall_cnt;

    initial begin
        vecs[0]  = '{"lb",     3'b000, 1,0,1,1,1, 32'h0000_1003, 32'h0,         32'h80FF_0000, 1,0,0,0,0, 4'b1000, 32'h0,         32'hFFFF_FF80, 1};
        vecs[1]  = '{"sh",     3'b001, 0,1,0,0,1, 32'h0000_2002, 32'h0000_ABCD, 32'h1234_5678, 1,0,0,0,0, 4'b1100, 32'hABCD_ABCD, 32'h0,         0};
        vecs[2]  = '{"lbu",    3'b100, 1,0,1,1,1, 32'h0000_1002, 32'h0,         32'h0080_0000, 1,0,0,0,0, 4'b0100, 32'h0,         32'h0000_0080, 1};
        vecs[3]  = '{"lh",     3'b001, 1,0,1,1,1, 32'h0000_0002, 32'h0,         32'h8001_1234, 1,0,0,0,0, 4'b1100, 32'h0,         32'hFFFF_8001, 1};
        vecs[4]  = '{"lhu",    3'b101, 1,0,1,1,1, 32'h0000_0000, 32'h0,         32'h8001_F234, 1,0,0,0,0, 4'b0011, 32'h0,         32'h0000_F234, 1};
        vecs[5]  = '{"lw",     3'b010, 1,0,1,1,1, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 1,0,0,0,0, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1};
        vecs[6]  = '{"sb",     3'b000, 0,1,0,0,1, 32'h0000_4001, 32'h1122_3344, 32'h0,         1,0,0,0,0, 4'b0010, 32'h4444_4444, 32'h0,         0};
        vecs[7]  = '{"sw",     3'b010, 0,1,0,0,1, 32'h0000_5004, 32'hCAFE_F00D, 32'h0,         1,0,0,0,0, 4'b1111, 32'hCAFE_F00D, 32'h0,         0};
        vecs[8]  = '{"lh_mis", 3'b001, 1,0,1,1,1, 32'h0000_0001, 32'h0,         32'h0,         0,1,0,0,1, 4'b0011, 32'h0,         32'h0,         0};
        vecs[9]  = '{"lw_mis", 3'b010, 1,0,1,1,1, 32'h0000_0102, 32'h0,         32'h0,         0,1,0,0,1, 4'b1111, 32'h0,         32'h0,         0};
        vecs[10] = '{"sw_mis", 3'b010, 0,1,0,0,1, 32'h0000_0203, 32'h0000_0055, 32'h0,         0,0,1,0,0, 4'b1111, 32'h0000_0055, 32'h0,         0};
        vecs[11] = '{"sh_mis", 3'b001, 0,1,0,0,1, 32'h0000_0005, 32'h0000_BEEF, 32'h0,         0,0,1,0,0, 4'b0011, 32'hBEEF_BEEF, 32'h0,         0};
        vecs[12] = '{"add",    3'b000, 0,0,1,0,1, 32'h0000_1234, 32'h0,         32'h0,         0,0,0,1,0, 4'b0001, 32'h0,         32'h0,         0};
        vecs[13] = '{"inv_lw", 3'b010, 1,0,1,1,0, 32'h0000_3000, 32'h0,         32'h0,         0,0,0,0,0, 4'b1111, 32'h0,         32'h0,         0};

        rst = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req",     {31'd0, dm_req},       32'd0);
        chk("rst.stall",   {31'd0, stall_req},    32'd0);
        chk("rst.regwr",   {31'd0, mem_RegWrite}, 32'd0);
        chk("rst.excp",    {30'd0, excp_adel, excp_ades}, 32'd0);
        chk("rst.memdata", memdata,               32'd0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 14; i++)
            run_vec(vecs[i]);

        // LW with the ack on the fourth WAIT cycle: 5 stalled cycles, bus stable.
        @(posedge clk); #1;
        apply(3'b010, 1, 0, 1, 1, 1, 32'h0000_6008, 32'h0);
        stall_cnt = 0;
        @(negedge clk);
        if (stall_req) stall_cnt++;
        chk("dly.req_idle", {31'd0, dm_req}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D; end
            @(negedge clk);
            if (stall_req) stall_cnt++;
            chk("dly.req",   {31'd0, dm_req},       32'd1);
            chk("dly.rw",    {31'd0, mem_RegWrite}, 32'd0);
            chk("dly.addr",  dm_addr,               32'h0000_6008);
            chk("dly.wstrb", {28'd0, dm_wstrb},     32'hF);
            chk("dly.we",    {31'd0, dm_we},        32'd0);
        end
        @(posedge clk); #1 dm_ack = 1'b0;
        @(negedge clk);
        if (stall_req) stall_cnt++;
        chk("dly.stall_cnt", stall_cnt,  32'd5);
        chk("dly.memdata",   memdata,    32'h0BAD_F00D);
        chk("dly.rw_resp",   {31'd0, mem_RegWrite}, 32'd1);

        // Back-to-back: the next op arrives in the IDLE cycle after RESP.
        @(posedge clk); #1;
        apply(3'b000, 1, 0, 1, 1, 1, 32'h0000_7001, 32'h0);
        @(negedge clk);
        chk("b2b.gap_req",   {31'd0, dm_req},    32'd0);
        chk("b2b.gap_stall", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #1 dm_ack = 1'b1; dm_rdata = 32'h0000_7F00;
        @(negedge clk);
        chk("b2b.req", {31'd0, dm_req}, 32'd1);
        @(posedge clk); #1 dm_ack = 1'b0;
        @(negedge clk);
        chk("b2b.memdata", memdata, 32'h0000_007F);
        @(posedge clk); #1 clear_inputs();

        // Reset in WAIT, then a late ack arriving in IDLE.
        @(posedge clk); #1;
        apply(3'b010, 1, 0, 1, 1, 1, 32'h0000_8000, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw.req_wait", {31'd0, dm_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstw.req_drop", {31'd0, dm_req}, 32'd0);
        clear_inputs();
        @(posedge clk); #1 rst = 1'b1;
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rstw.req_idle",   {31'd0, dm_req},    32'd0);
        chk("rstw.stall_idle", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1 dm_ack = 1'b0;
        ex_MemRead = 1'b1; ex_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw.no_resp", memdata, 32'd0);
            chk("rstw.no_req",  {31'd0, dm_req}, 32'd0);
            @(posedge clk); #1;
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
